// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a valid/ready
// memory port and holds the instruction for decode until commit.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        Updated_PC,
  input  logic               Pc_Commit,
  output logic [31:0]        Current_PC,
  output logic               Imem_Req_Valid,
  output logic [31:0]        Imem_Req_Addr,
  input  logic               Imem_Req_Ready,
  input  logic               Imem_Rsp_Valid,
  input  logic [31:0]        Imem_Rsp_Data,
  input  logic               Imem_Rsp_Err,
  output logic [31:0]        Instr,
  output logic               Instr_Valid,
  output logic               Fetch_Fault,
  output logic [COUNT_W-1:0] Instr_Count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic rsp_ok;
  logic rsp_err;
  logic commit_acc;
  logic misaligned;

  assign misaligned = Updated_PC[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (Imem_Req_Ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (Imem_Rsp_Valid) begin
          state_nxt = Imem_Rsp_Err ? S_FAULT : S_HOLD;
        end
      end
      S_HOLD: begin
        if (Pc_Commit) begin
          state_nxt = misaligned ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  // Responses and commits only count in their own state.
  always_comb begin
    Imem_Req_Valid = 1'b0;
    rsp_ok         = 1'b0;
    rsp_err        = 1'b0;
    commit_acc     = 1'b0;
    unique case (state)
      S_REQ:   Imem_Req_Valid = 1'b1;
      S_WAIT: begin
        rsp_ok  = Imem_Rsp_Valid & ~Imem_Rsp_Err;
        rsp_err = Imem_Rsp_Valid &  Imem_Rsp_Err;
      end
      S_HOLD:  commit_acc = Pc_Commit;
      S_FAULT: Imem_Req_Valid = 1'b0;
      default: Imem_Req_Valid = 1'b0;
    endcase
  end

  assign Imem_Req_Addr = Current_PC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Current_PC  <= RESET_PC;
      Instr       <= '0;
      Instr_Valid <= 1'b0;
      Fetch_Fault <= 1'b0;
      Instr_Count <= '0;
    end else begin
      if (rsp_ok) begin
        Instr       <= Imem_Rsp_Data;
        Instr_Valid <= 1'b1;
      end
      if (rsp_err) begin
        Fetch_Fault <= 1'b1;
      end
      // A misaligned target is still loaded so debug can see it.
      if (commit_acc) begin
        Current_PC  <= Updated_PC;
        Instr_Count <= Instr_Count + COUNT_W'(1);
        Instr_Valid <= 1'b0;
        if (misaligned) Fetch_Fault <= 1'b1;
      end
    end
  end

endmodule
